qq_value_router_seq: RTL and testbench

//  Sequential, parametrised successor to the QuickQ value router: owns a sorted priority array in
//  an external 1-cycle-latency BRAM and executes ENQ/DEQ/REPL ops by scanning it, routing
//  the preferred key into each slot and carrying the other key onward. Sits between the QuickQ

---
 rtl/qq_value_router_seq_if.sv | 35 +++
 rtl/qq_value_router_seq.sv | 214 +++++++++++++++++++++
 tb/tb_qq_value_router_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/qq_value_router_seq_if.sv
// Command, result and key-BRAM signals of the sequential QuickQ value router.
// master = command issuer / BRAM owner, slave = the router itself.
interface qq_value_router_seq_if #(
    parameter int KEY_W  = 32,
    parameter int ADDR_W = 4
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [KEY_W-1:0]  op_key;
    logic              bram_rd_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [KEY_W-1:0]  bram_rdata;
    logic              bram_we;
    logic [KEY_W-1:0]  bram_wdata;
    logic              done;
    logic              res_valid;
    logic [KEY_W-1:0]  res_key;
    logic              err;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    modport master (
        output op_valid, op_code, op_key, bram_rdata,
        input  op_ready, bram_rd_en, bram_addr, bram_we, bram_wdata,
        input  done, res_valid, res_key, err, count, full, empty
    );

    modport slave (
        input  op_valid, op_code, op_key, bram_rdata,
        output op_ready, bram_rd_en, bram_addr, bram_we, bram_wdata,
        output done, res_valid, res_key, err, count, full, empty
    );
endinterface

// File: rtl/qq_value_router_seq.sv
// Sequential QuickQ value router: keeps a sorted key array in a 1-cycle BRAM and
// services ENQ/DEQ/REPL by one read/compare/write pass over the occupied entries.
module qq_value_router_seq #(
    parameter int KEY_W     = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter bit MIN_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    qq_value_router_seq_if.slave  io
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_TAIL, S_DONE} state_t;

    localparam logic [1:0]      OP_NOP  = 2'd0;
    localparam logic [1:0]      OP_ENQ  = 2'd1;
    localparam logic [1:0]      OP_DEQ  = 2'd2;
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [KEY_W-1:0]  res_key_q, res_key_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              res_vld_q, res_vld_d;
    logic              ready_q, ready_d;

    logic              rd_en, we;
    logic [ADDR_W:0]   addr;
    logic [KEY_W-1:0]  wdata;
    logic [ADDR_W:0]   idx_nxt, idx_m1, cnt_m1;
    logic              last, is_full, is_empty;

    // Strict order: an equal incoming key never displaces a stored one.
    function automatic logic prefer(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        prefer = MIN_FIRST ? (a < b) : (a > b);
    endfunction

    assign idx_nxt  = idx_q + ONE;
    assign idx_m1   = idx_q - ONE;
    assign cnt_m1   = count_q - ONE;
    assign last     = (idx_nxt == count_q);
    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        key_d     = key_q;
        idx_d     = idx_q;
        count_d   = count_q;
        res_key_d = res_key_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        res_vld_d = 1'b0;
        rd_en     = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        case (state_q)
            S_IDLE: begin
                if (io.op_valid) begin
                    op_d  = io.op_code;
                    key_d = io.op_key;
                    idx_d = '0;
                    case (io.op_code)
                        OP_NOP: begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                        OP_ENQ: begin
                            if (is_full) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                err_d   = 1'b1;
                            end else begin
                                state_d = is_empty ? S_TAIL : S_RD;
                            end
                        end
                        default: begin
                            if (is_empty) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_RD;
                            end
                        end
                    endcase
                end
            end
            S_RD: begin
                rd_en   = 1'b1;
                addr    = idx_q;
                state_d = S_WR;
            end
            S_WR: begin
                case (op_q)
                    OP_ENQ: begin
                        // Rewrite every slot; the losing key rides on to the next one.
                        we    = 1'b1;
                        addr  = idx_q;
                        idx_d = idx_nxt;
                        if (prefer(key_q, io.bram_rdata)) begin
                            wdata = key_q;
                            key_d = io.bram_rdata;
                        end else begin
                            wdata = io.bram_rdata;
                        end
                        state_d = last ? S_TAIL : S_RD;
                    end
                    OP_DEQ: begin
                        idx_d = idx_nxt;
                        if (idx_q == '0) begin
                            res_key_d = io.bram_rdata;
                        end else begin
                            we    = 1'b1;
                            addr  = idx_m1;
                            wdata = io.bram_rdata;
                        end
                        if (last) begin
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            res_vld_d = 1'b1;
                            count_d   = cnt_m1;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                    default: begin
                        if (idx_q == '0) begin
                            res_key_d = io.bram_rdata;
                            idx_d     = idx_nxt;
                            state_d   = last ? S_TAIL : S_RD;
                        end else begin
                            we   = 1'b1;
                            addr = idx_m1;
                            if (prefer(key_q, io.bram_rdata)) begin
                                // New key lands here; the rest of the array is already in order.
                                wdata     = key_q;
                                state_d   = S_DONE;
                                done_d    = 1'b1;
                                res_vld_d = 1'b1;
                            end else begin
                                wdata   = io.bram_rdata;
                                idx_d   = idx_nxt;
                                state_d = last ? S_TAIL : S_RD;
                            end
                        end
                    end
                endcase
            end
            S_TAIL: begin
                we      = 1'b1;
                wdata   = key_q;
                state_d = S_DONE;
                done_d  = 1'b1;
                if (op_q == OP_ENQ) begin
                    addr    = count_q;
                    count_d = count_q + ONE;
                end else begin
                    addr      = cnt_m1;
                    res_vld_d = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            key_q     <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            res_key_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            res_vld_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            key_q     <= key_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            res_key_q <= res_key_d;
            done_q    <= done_d;
            err_q     <= err_d;
            res_vld_q <= res_vld_d;
            ready_q   <= ready_d;
        end
    end

    assign io.op_ready   = ready_q;
    assign io.bram_rd_en = rd_en;
    assign io.bram_we    = we;
    assign io.bram_addr  = addr[ADDR_W-1:0];
    assign io.bram_wdata = wdata;
    assign io.done       = done_q;
    assign io.err        = err_q;
    assign io.res_valid  = res_vld_q;
    assign io.res_key    = res_key_q;
    assign io.count      = count_q;
    assign io.full       = is_full;
    assign io.empty      = is_empty;
endmodule

// File: tb/tb_qq_value_router_seq.sv
// Scoreboard bench for qq_value_router_seq: a sorted-queue model predicts each op's
// result, latency and array contents; a negedge monitor checks them at every done.
module tb_qq_value_router_seq;
    localparam int KW = 32;
    localparam int D  = 4;
    localparam int AW = 2;

    typedef struct {
        int               lat;
        bit               err;
        bit               rv;
        logic [KW-1:0]    res;
        int               cnt;
        logic [D-1:0][KW-1:0] arr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    qq_value_router_seq_if #(.KEY_W(KW), .ADDR_W(AW)) a ();
    qq_value_router_seq_if #(.KEY_W(KW), .ADDR_W(AW)) b ();

    qq_value_router_seq #(.KEY_W(KW), .DEPTH(D), .ADDR_W(AW), .MIN_FIRST(1'b1))
        dut0 (.clk(clk), .rst(rst), .io(a));
    qq_value_router_seq #(.KEY_W(KW), .DEPTH(D), .ADDR_W(AW), .MIN_FIRST(1'b0))
        dut1 (.clk(clk), .rst(rst), .io(b));

    logic [KW-1:0] mem0 [D];
    logic [KW-1:0] mem1 [D];

    always @(posedge clk) begin
        if (a.bram_we) mem0[a.bram_addr] <= a.bram_wdata;
        if (a.bram_rd_en) a.bram_rdata <= mem0[a.bram_addr];
        if (b.bram_we) mem1[b.bram_addr] <= b.bram_wdata;
        if (b.bram_rd_en) b.bram_rdata <= mem1[b.bram_addr];
    end

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int unsigned mq[$];
    logic [KW-1:0] last_res = '0;
    exp_t sb[$];
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: keys kept ascending; an inserted key goes after every stored key <= it.
    function automatic int ins_pos(input int unsigned key);
        int p = 0;
        foreach (mq[i]) if (mq[i] <= key) p++;
        return p;
    endfunction

    task automatic issue(input logic [1:0] code, input logic [KW-1:0] key);
        exp_t e;
        int n, p;
        bit got;
        @(negedge clk);
        for (int k = 0; k < 50 && !a.op_ready; k++) @(negedge clk);
        n = mq.size();
        e.lat = 1; e.err = 1'b0; e.rv = 1'b0; e.arr = '0;
        case (code)
            2'd1: if (n == D) e.err = 1'b1;
                  else begin
                      e.lat = 2 * n + 2;
                      mq.insert(ins_pos(key), key);
                  end
            2'd2: if (n == 0) e.err = 1'b1;
                  else begin
                      last_res = mq.pop_front();
                      e.rv = 1'b1;
                      e.lat = 2 * n + 1;
                  end
            2'd3: if (n == 0) e.err = 1'b1;
                  else begin
                      last_res = mq.pop_front();
                      e.rv = 1'b1;
                      p = ins_pos(key);
                      e.lat = (p < n - 1) ? 2 * p + 5 : 2 * n + 2;
                      mq.insert(p, key);
                  end
            default: ;
        endcase
        e.res = last_res;
        e.cnt = mq.size();
        for (int i = 0; i < mq.size(); i++) e.arr[i] = mq[i];
        sb.push_back(e);
        a.op_valid = 1'b1; a.op_code = code; a.op_key = key;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        a.op_valid = 1'b0; a.op_code = 2'($urandom); a.op_key = $urandom;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a.done) begin got = 1'b1; break; end
        end
        if (!got) chk("op_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a.bram_we && a.bram_rd_en) chk("rd_we_overlap", 1, 0);
            if (a.done) begin
                if (sb.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    me = sb.pop_front();
                    chk("latency", cyc - acc_cyc + 1, me.lat);
                    chk("err", a.err, me.err);
                    chk("res_valid", a.res_valid, me.rv);
                    chk("res_key", a.res_key, me.res);
                    chk("count", a.count, me.cnt);
                    chk("full", a.full, me.cnt == D);
                    chk("empty", a.empty, me.cnt == 0);
                    for (int i = 0; i < me.cnt; i++) chk("bram", mem0[i], me.arr[i]);
                end
            end
        end
    end

    initial begin
        int wes;
        bit got;
        logic [KW-1:0] bk [2];
        a.op_valid = 1'b0; a.op_code = 2'd0; a.op_key = '0;
        b.op_valid = 1'b0; b.op_code = 2'd0; b.op_key = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", a.op_ready, 1);
        chk("rst_empty", a.empty, 1);
        chk("rst_count", a.count, 0);
        chk("rst_done", a.done, 0);
        chk("rst_we", a.bram_we, 0);
        rst = 1'b0;

        issue(2'd1, 2); issue(2'd1, 1); issue(2'd1, 5);
        issue(2'd2, 0);
        issue(2'd1, 9);
        issue(2'd3, 6);
        issue(2'd1, 5);
        issue(2'd1, 32'hf680d628);
        chk("full_after_err", a.full, 1);
        repeat (4) issue(2'd2, 0);
        issue(2'd2, 0);
        issue(2'd3, 7);
        issue(2'd0, 0);

        repeat (80) begin
            logic [KW-1:0] k;
            k = ($urandom_range(0, 3) == 0) ? KW'($urandom) : KW'($urandom_range(0, 12));
            issue(2'($urandom_range(0, 3)), k);
        end

        while (mq.size() > 0) issue(2'd2, 0);
        issue(2'd1, 3); issue(2'd1, 7);

        // Abort an ENQ mid-scan with an async reset pulse.
        @(negedge clk);
        a.op_valid = 1'b1; a.op_code = 2'd1; a.op_key = 4;
        @(posedge clk);
        #1 a.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", a.op_ready, 1);
        chk("midrst_count", a.count, 0);
        chk("midrst_empty", a.empty, 1);
        mq.delete(); sb.delete(); last_res = '0;
        wes = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a.bram_we) wes++;
        end
        chk("midrst_no_we", wes, 0);
        issue(2'd1, 8);
        issue(2'd2, 0);

        bk[0] = 2; bk[1] = 9;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            b.op_valid = 1'b1; b.op_code = 2'd1; b.op_key = bk[j];
            @(posedge clk);
            #1 b.op_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (b.done) begin got = 1'b1; break; end
            end
            chk("maxfirst_done", got, 1);
        end
        chk("maxfirst_bram0", mem1[0], 9);
        chk("maxfirst_bram1", mem1[1], 2);
        chk("maxfirst_count", b.count, 2);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
